// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared encodings for the UART transmit path. This package holds
//               the frame-sequencer state encoding, the output-mux select codes
//               and a counter-width helper.
// Revision    : 1.0  initial release
// ============================================================================
package uart_tx_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // TX output mux select codes, also decoded by the 4:1 output mux
    localparam logic [1:0] MUX_START = 2'b00;   // drives 0
    localparam logic [1:0] MUX_IDLE  = 2'b01;   // drives 1 (idle / stop)
    localparam logic [1:0] MUX_DATA  = 2'b10;   // drives ser_data
    localparam logic [1:0] MUX_PAR   = 2'b11;   // drives par_bit

    // Width of a counter that must hold 0..n-1. The result is never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_tick
// Description : Baud prescaler. It counts 0..PRESCALE-1 while enabled, wraps
//               to 0 on the terminal count and raises tick_o on that cycle.
//               clr_i restarts the count so that a new frame is aligned to
//               its accept cycle.
// Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick
    import uart_tx_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW     = cnt_w(PRESCALE);
    localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Terminal count, valid only while the sequencer is running
    always_comb begin
        tick_o = en_i && (cnt_q == C_LAST);
    end

    // Next count: clear, wrap on tick, or advance while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescale counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : uart_baud_tick
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit frame sequencer. It accepts a byte through a
//               valid/ready handshake, computes its parity, paces bits with a
//               baud prescaler, strobes the serializer once per data bit and
//               steers the TX output mux through start/data/parity/stop.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int PRESCALE    = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DATA_LENGTH-1:0] p_data_i,
    input  logic                   data_valid_i,
    input  logic                   par_en_i,
    input  logic                   par_typ_i,
    output logic                   data_ready_o,
    output logic                   ser_en_o,
    output logic [1:0]             mux_sel_o,
    output logic                   par_bit_o,
    output logic                   busy_o
);

    localparam int            BW         = cnt_w(DATA_LENGTH);
    localparam int            SW         = cnt_w(STOP_BITS);
    localparam logic [BW-1:0] C_BIT_LAST = BW'(DATA_LENGTH - 1);
    localparam logic [SW-1:0] C_STP_LAST = SW'(STOP_BITS - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] stop_cnt_q, stop_cnt_d;
    logic          par_en_q;
    logic          par_bit_q;
    logic          tick;
    logic          accept;
    logic          last_bit;
    logic          last_stop;

    // The prescaler runs in every non-idle state and realigns on each accept
    uart_baud_tick #(
        .PRESCALE (PRESCALE)
    ) u_baud_tick (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (state_q != ST_IDLE),
        .clr_i  (accept),
        .tick_o (tick)
    );

    // Handshake: ready in idle, or on the final stop tick for back-to-back frames
    always_comb begin
        last_bit     = (bit_cnt_q == C_BIT_LAST);
        last_stop    = (stop_cnt_q == C_STP_LAST);
        data_ready_o = (state_q == ST_IDLE) ||
                       ((state_q == ST_STOP) && last_stop && tick);
        accept       = data_valid_i && data_ready_o;
    end

    // State register plus per-frame latched configuration
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            if (accept) begin
                par_en_q  <= par_en_i;
                par_bit_q <= par_typ_i ? ~^p_data_i : ^p_data_i;
            end
        end
    end

    // Next-state and per-state bit counters; counters idle at 0 outside their state
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_START;
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                bit_cnt_d = bit_cnt_q;
                if (tick) begin
                    if (last_bit) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                stop_cnt_d = stop_cnt_q;
                if (tick) begin
                    if (last_stop) begin
                        state_d = accept ? ST_START : ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore mux select and busy; ser_en strobes on the ticks that load a data bit
    always_comb begin
        mux_sel_o = MUX_IDLE;
        busy_o    = (state_q != ST_IDLE);
        ser_en_o  = 1'b0;
        par_bit_o = par_bit_q;
        case (state_q)
            ST_START: begin
                mux_sel_o = MUX_START;
                ser_en_o  = tick;
            end
            ST_DATA: begin
                mux_sel_o = MUX_DATA;
                ser_en_o  = tick && !last_bit;
            end
            ST_PARITY: mux_sel_o = MUX_PAR;
            default:   mux_sel_o = MUX_IDLE;
        endcase
    end

endmodule : uart_tx_ctrl
`default_nettype wire
